// File: rtl/regfile_access_arbiter_pkg.sv
// Shared constants for the register-file access arbiter.
package regfile_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;

  // Transaction kind as carried on req_write.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Next round-robin position after index idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_access_arbiter_rr.sv
// Combinational round-robin picker: scans req starting at ptr, upward with wrap,
// and grants the first requester found (one-hot gnt plus its encoded index).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic           found;
  logic [IDX_W:0] cand;

  // Priority scan from ptr; the first requesting slot wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDX_W-1:0]]  = 1'b1;
        idx                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one register-file port between NUM_REQ requesters.
// Handshake: a requester raises req_valid with stable write/addr/wdata and keeps
// them until req_ready is seen high in the same cycle; that cycle is the accept.
// Accept in cycle T -> register-file access in T+1 -> read response pulse in T+2.
module regfile_access_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      rf_wEnable,
  output logic                      rf_rEnable,
  input  logic [DATA_W-1:0]         rf_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   tag;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               accept;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // No grants while reset is held low.
  assign req_ready = reset ? gnt : '0;
  assign accept    = |req_ready;

  // Select the granted requester's transaction fields.
  always_comb begin
    sel_write = req_write[gnt_idx];
    sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  // Round-robin pointer moves past the winner only on an accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= IDX_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
    end
  end

  // Stage 1: drive the register-file port for one cycle per accepted transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_wEnable <= 1'b0;
      rf_rEnable <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      tag        <= '0;
    end else begin
      rf_wEnable <= accept && (sel_write == OP_WRITE);
      rf_rEnable <= accept && (sel_write == OP_READ);
      if (accept) begin
        rf_addr  <= sel_addr;
        rf_wdata <= sel_wdata;
        tag      <= gnt_idx;
      end
    end
  end

  // Stage 2: capture read data and pulse the originating requester's rsp_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rf_rEnable ? (NUM_REQ'(1) << tag) : '0;
      if (rf_rEnable) begin
        rsp_rdata <= rf_rdata;
      end
    end
  end

endmodule
